// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM with memory handshake, timeout watchdog and illegal-opcode flag.
// Optional PERF_COUNTER_EN adds cycle and retired-instruction counters.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [31:0]      i_instruction,
  input  logic             i_zero,
  input  logic             i_mem_ready,
  output logic             o_pc_write,
  output logic             o_iord,
  output logic             o_ir_write,
  output logic             o_mem_read,
  output logic             o_mem_write,
  output logic             o_reg_dst,
  output logic             o_mem_to_reg,
  output logic             o_reg_write,
  output logic             o_alu_src_a,
  output logic [1:0]       o_alu_src_b,
  output logic [1:0]       o_alu_op,
  output logic [1:0]       o_pc_src,
  output logic             o_illegal_op,
  output logic             o_mem_timeout,
`ifdef PERF_COUNTER_EN
  output logic [CNT_W-1:0] o_cycle_count,
  output logic [CNT_W-1:0] o_instr_count,
`endif
  output logic [3:0]       o_state
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_I_EXEC    = 4'd11,
    S_I_WB      = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam int WD_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = (MEM_TIMEOUT > 0) ? WD_W'(MEM_TIMEOUT - 1) : '0;
  localparam logic WD_EN = (MEM_TIMEOUT > 0);

  state_t          r_state;
  state_t          w_next_state;
  logic [WD_W-1:0] r_wd_cnt;
  logic            r_illegal_op;
  logic            r_mem_timeout;
  logic            w_mem_wait;
  logic            w_expire;
  logic            w_illegal_dec;
  logic [5:0]      w_opcode;
  logic            w_unused;

  assign w_opcode = i_instruction[31:26];
  assign w_unused = &{1'b0, i_instruction[25:0], (CNT_W > 0)};

  // A memory-facing state stalled on the handshake is what the watchdog measures.
  assign w_mem_wait = ((r_state == S_FETCH) || (r_state == S_MEM_READ) || (r_state == S_MEM_WRITE))
                      && !i_mem_ready;
  assign w_expire   = WD_EN && w_mem_wait && (r_wd_cnt == WD_LAST);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; an expired watchdog abandons the instruction and refetches
  always_comb begin
    w_next_state  = r_state;
    w_illegal_dec = 1'b0;
    case (r_state)
      S_IDLE:      w_next_state = S_FETCH;
      S_FETCH: begin
        if (i_mem_ready) begin
          w_next_state = S_DECODE;
        end else begin
          w_next_state = S_FETCH;
        end
      end
      S_DECODE: begin
        case (w_opcode)
          OP_RTYPE:      w_next_state = S_R_EXEC;
          OP_LW, OP_SW:  w_next_state = S_MEM_ADDR;
          OP_BEQ:        w_next_state = S_BRANCH;
          OP_J:          w_next_state = S_JUMP;
          OP_ADDI:       w_next_state = S_I_EXEC;
          default: begin
            w_illegal_dec = 1'b1;
            w_next_state  = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        case (w_opcode)
          OP_LW:   w_next_state = S_MEM_READ;
          OP_SW:   w_next_state = S_MEM_WRITE;
          default: w_next_state = S_FETCH;
        endcase
      end
      S_MEM_READ: begin
        if (i_mem_ready) begin
          w_next_state = S_MEM_WB;
        end else if (w_expire) begin
          w_next_state = S_FETCH;
        end else begin
          w_next_state = S_MEM_READ;
        end
      end
      S_MEM_WRITE: begin
        if (i_mem_ready || w_expire) begin
          w_next_state = S_FETCH;
        end else begin
          w_next_state = S_MEM_WRITE;
        end
      end
      S_R_EXEC:    w_next_state = S_R_WB;
      S_I_EXEC:    w_next_state = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: w_next_state = S_FETCH;
      default:     w_next_state = S_IDLE;
    endcase
  end

  // Watchdog counter and sticky error flags
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wd_cnt      <= '0;
      r_illegal_op  <= 1'b0;
      r_mem_timeout <= 1'b0;
    end else begin
      if (WD_EN && w_mem_wait && !w_expire) begin
        r_wd_cnt <= r_wd_cnt + WD_W'(1);
      end else begin
        r_wd_cnt <= '0;
      end
      r_illegal_op  <= r_illegal_op | w_illegal_dec;
      r_mem_timeout <= r_mem_timeout | w_expire;
    end
  end

  // Moore control decode; PCWrite/IRWrite additionally qualified by MemReady/Zero
  always_comb begin
    o_pc_write   = 1'b0;
    o_iord       = 1'b0;
    o_ir_write   = 1'b0;
    o_mem_read   = 1'b0;
    o_mem_write  = 1'b0;
    o_reg_dst    = 1'b0;
    o_mem_to_reg = 1'b0;
    o_reg_write  = 1'b0;
    o_alu_src_a  = 1'b0;
    o_alu_src_b  = 2'b00;
    o_alu_op     = 2'b00;
    o_pc_src     = 2'b00;
    case (r_state)
      S_FETCH: begin
        o_mem_read  = 1'b1;
        o_alu_src_b = 2'b01;
        o_ir_write  = i_mem_ready;
        o_pc_write  = i_mem_ready;
      end
      S_DECODE:    o_alu_src_b = 2'b11;
      S_MEM_ADDR, S_I_EXEC: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        o_mem_read = 1'b1;
        o_iord     = 1'b1;
      end
      S_MEM_WB: begin
        o_reg_write  = 1'b1;
        o_mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        o_mem_write = 1'b1;
        o_iord      = 1'b1;
      end
      S_R_EXEC: begin
        o_alu_src_a = 1'b1;
        o_alu_op    = 2'b10;
      end
      S_R_WB: begin
        o_reg_write = 1'b1;
        o_reg_dst   = 1'b1;
      end
      S_I_WB:      o_reg_write = 1'b1;
      S_BRANCH: begin
        o_alu_src_a = 1'b1;
        o_alu_op    = 2'b01;
        o_pc_src    = 2'b01;
        o_pc_write  = i_zero;
      end
      S_JUMP: begin
        o_pc_src   = 2'b10;
        o_pc_write = 1'b1;
      end
      default: o_pc_write = 1'b0;
    endcase
  end

  assign o_illegal_op  = r_illegal_op;
  assign o_mem_timeout = r_mem_timeout;
  assign o_state       = r_state;

`ifdef PERF_COUNTER_EN
  logic [CNT_W-1:0] r_cycle_count;
  logic [CNT_W-1:0] r_instr_count;
  logic             w_retire;

  // sw retires from MEM_WRITE on completion; a watchdog abort is not a retirement
  assign w_retire = (w_next_state == S_FETCH) && !w_expire &&
                    ((r_state == S_MEM_WB) || (r_state == S_R_WB) || (r_state == S_I_WB) ||
                     (r_state == S_BRANCH) || (r_state == S_JUMP) || (r_state == S_MEM_WRITE));

  // Free-running performance counters, wrapping naturally
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cycle_count <= '0;
      r_instr_count <= '0;
    end else begin
      r_cycle_count <= r_cycle_count + CNT_W'(1);
      if (w_retire) begin
        r_instr_count <= r_instr_count + CNT_W'(1);
      end else begin
        r_instr_count <= r_instr_count;
      end
    end
  end

  assign o_cycle_count = r_cycle_count;
  assign o_instr_count = r_instr_count;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed vector table, hand-written corner sequences,
// and randomized traffic checked against an instruction-level reference model.
module tb_multicycle_controller;

  localparam int TO = 4;

  localparam logic [31:0] I_ADD  = 32'h012A4020;
  localparam logic [31:0] I_LW   = 32'h8D090004;
  localparam logic [31:0] I_SW   = 32'hAD090004;
  localparam logic [31:0] I_BEQ  = 32'h11090002;
  localparam logic [31:0] I_J    = 32'h08000010;
  localparam logic [31:0] I_ADDI = 32'h21290001;
  localparam logic [31:0] I_ILL  = 32'hFC000000;
  localparam logic [31:0] I_LUI  = 32'h3C010000;

  logic clk, rst_n, zero, rdy;
  logic [31:0] instr;

  logic pcw, iord, irw, mr, mw, rd, m2r, rw, asa, ill, to;
  logic [1:0] asb, aop, pcs;
  logic [3:0] st;
  logic pcw0, iord0, irw0, mr0, mw0, rd0, m2r0, rw0, asa0, ill0, to0;
  logic [1:0] asb0, aop0, pcs0;
  logic [3:0] st0;

  wire [14:0] d_ctl  = {pcw, iord, irw, mr, mw, rd, m2r, rw, asa, asb, aop, pcs};
  wire [14:0] d_ctl0 = {pcw0, iord0, irw0, mr0, mw0, rd0, m2r0, rw0, asa0, asb0, aop0, pcs0};

  multicycle_controller #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_instruction(instr), .i_zero(zero), .i_mem_ready(rdy),
    .o_pc_write(pcw), .o_iord(iord), .o_ir_write(irw), .o_mem_read(mr), .o_mem_write(mw),
    .o_reg_dst(rd), .o_mem_to_reg(m2r), .o_reg_write(rw), .o_alu_src_a(asa),
    .o_alu_src_b(asb), .o_alu_op(aop), .o_pc_src(pcs), .o_illegal_op(ill),
    .o_mem_timeout(to), .o_state(st));

  multicycle_controller #(.MEM_TIMEOUT(0), .CNT_W(32)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_instruction(instr), .i_zero(zero), .i_mem_ready(rdy),
    .o_pc_write(pcw0), .o_iord(iord0), .o_ir_write(irw0), .o_mem_read(mr0), .o_mem_write(mw0),
    .o_reg_dst(rd0), .o_mem_to_reg(m2r0), .o_reg_write(rw0), .o_alu_src_a(asa0),
    .o_alu_src_b(asb0), .o_alu_op(aop0), .o_pc_src(pcs0), .o_illegal_op(ill0),
    .o_mem_timeout(to0), .o_state(st0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected control word {PCWrite,IorD,IRWrite,MemRead,MemWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSrc}
  function automatic logic [14:0] exp_ctl(input int s, input logic r, input logic z);
    case (s)
      1:  return {r, 1'b0, r, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00};
      2:  return {9'b0, 2'b11, 4'b0};
      3:  return {8'b0, 1'b1, 2'b10, 4'b0};
      4:  return {1'b0, 1'b1, 1'b0, 1'b1, 11'b0};
      5:  return {5'b0, 1'b0, 1'b1, 1'b1, 7'b0};
      6:  return {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 10'b0};
      7:  return {8'b0, 1'b1, 2'b00, 2'b10, 2'b00};
      8:  return {5'b0, 1'b1, 1'b0, 1'b1, 7'b0};
      9:  return {z, 7'b0, 1'b1, 2'b00, 2'b01, 2'b01};
      10: return {1'b1, 12'b0, 2'b10};
      11: return {8'b0, 1'b1, 2'b10, 4'b0};
      12: return {7'b0, 1'b1, 7'b0};
      default: return 15'b0;
    endcase
  endfunction

  // Reference model: each instruction class is the list of states it visits after DECODE
  typedef int q_t[$];
  int  m_state, m_wait;
  logic m_ill, m_to;
  q_t  m_rest;

  function automatic q_t path_of(input logic [5:0] op);
    q_t q;
    case (op)
      6'd0:  q = {7, 8};
      6'd35: q = {3, 4, 5};
      6'd43: q = {3, 6};
      6'd4:  q = {9};
      6'd2:  q = {10};
      6'd8:  q = {11, 12};
      default: q = {};
    endcase
    return q;
  endfunction

  task automatic model_reset();
    m_state = 0; m_wait = 0; m_ill = 1'b0; m_to = 1'b0;
    m_rest.delete();
  endtask

  task automatic model_step(input logic [31:0] ins, input logic r);
    int nxt;
    logic mem, expired;
    mem = (m_state == 1) || (m_state == 4) || (m_state == 6);
    expired = 1'b0;
    nxt = m_state;
    if (m_state == 0) begin
      nxt = 1;
    end else if (mem && !r) begin
      if (TO > 0 && m_wait == TO - 1) begin
        expired = 1'b1; m_to = 1'b1; nxt = 1; m_rest.delete();
      end
    end else if (m_state == 1) begin
      nxt = 2;
    end else begin
      if (m_state == 2) begin
        m_rest = path_of(ins[31:26]);
        if (m_rest.size() == 0) m_ill = 1'b1;
      end
      nxt = (m_rest.size() > 0) ? m_rest.pop_front() : 1;
    end
    m_wait = (mem && !r && !expired) ? m_wait + 1 : 0;
    m_state = nxt;
  endtask

  typedef struct {
    logic [31:0] ins;
    logic        r;
    logic        z;
    int          s;
    logic        il;
  } vec_t;
  vec_t vt[$];

  task automatic add_vec(input logic [31:0] ins, input logic r, input logic z, input int s, input logic il);
    vec_t v;
    v.ins = ins; v.r = r; v.z = z; v.s = s; v.il = il;
    vt.push_back(v);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic step(input string name, input logic [31:0] ins, input logic r, input logic z, input int s);
    instr = ins; rdy = r; zero = z;
    #1;
    chk({name, "_state"}, {28'b0, st}, s);
    chk({name, "_ctl"}, {17'b0, d_ctl}, {17'b0, exp_ctl(s, r, z)});
    @(posedge clk); #1;
  endtask

  int thr;

  initial begin
    rst_n = 1'b0; instr = I_ADD; rdy = 1'b1; zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {28'b0, st}, 32'd0);
    chk("reset_ctl", {17'b0, d_ctl}, 32'd0);
    chk("reset_flags", {30'b0, ill, to}, 32'd0);

    // Directed table: add, beq taken/not taken, j, addi, illegal opcode, FETCH stall
    add_vec(I_ADD, 1'b1, 1'b0, 0, 1'b0);  add_vec(I_ADD, 1'b1, 1'b0, 1, 1'b0);
    add_vec(I_ADD, 1'b1, 1'b0, 2, 1'b0);  add_vec(I_ADD, 1'b1, 1'b0, 7, 1'b0);
    add_vec(I_ADD, 1'b1, 1'b0, 8, 1'b0);
    add_vec(I_BEQ, 1'b1, 1'b1, 1, 1'b0);  add_vec(I_BEQ, 1'b1, 1'b1, 2, 1'b0);
    add_vec(I_BEQ, 1'b1, 1'b1, 9, 1'b0);
    add_vec(I_BEQ, 1'b1, 1'b0, 1, 1'b0);  add_vec(I_BEQ, 1'b1, 1'b0, 2, 1'b0);
    add_vec(I_BEQ, 1'b1, 1'b0, 9, 1'b0);
    add_vec(I_J,   1'b1, 1'b0, 1, 1'b0);  add_vec(I_J,   1'b1, 1'b0, 2, 1'b0);
    add_vec(I_J,   1'b1, 1'b0, 10, 1'b0);
    add_vec(I_ADDI, 1'b1, 1'b0, 1, 1'b0); add_vec(I_ADDI, 1'b1, 1'b0, 2, 1'b0);
    add_vec(I_ADDI, 1'b1, 1'b0, 11, 1'b0); add_vec(I_ADDI, 1'b1, 1'b0, 12, 1'b0);
    add_vec(I_ILL, 1'b1, 1'b0, 1, 1'b0);  add_vec(I_ILL, 1'b1, 1'b0, 2, 1'b0);
    add_vec(I_ADD, 1'b0, 1'b0, 1, 1'b1);  add_vec(I_ADD, 1'b1, 1'b0, 1, 1'b1);
    add_vec(I_ADD, 1'b1, 1'b0, 2, 1'b1);

    rst_n = 1'b1;
    for (int i = 0; i < vt.size(); i++) begin
      instr = vt[i].ins; rdy = vt[i].r; zero = vt[i].z;
      #1;
      chk($sformatf("vec%0d_state", i), {28'b0, st}, vt[i].s);
      chk($sformatf("vec%0d_ctl", i), {17'b0, d_ctl}, {17'b0, exp_ctl(vt[i].s, vt[i].r, vt[i].z)});
      chk($sformatf("vec%0d_flags", i), {30'b0, ill, to}, {30'b0, vt[i].il, 1'b0});
      chk($sformatf("vec%0d_nowd", i), {13'b0, st0, d_ctl0}, {13'b0, st, d_ctl});
      @(posedge clk); #1;
    end

    // lw with MemReady low for 3 cycles; ready arrives on the would-be expiry cycle
    do_reset();
    step("lw_idle", I_LW, 1'b1, 1'b0, 0);
    step("lw_fetch", I_LW, 1'b1, 1'b0, 1);
    step("lw_dec", I_LW, 1'b1, 1'b0, 2);
    step("lw_addr", I_LW, 1'b1, 1'b0, 3);
    for (int i = 0; i < 3; i++) step("lw_wait", I_LW, 1'b0, 1'b0, 4);
    step("lw_done", I_LW, 1'b1, 1'b0, 4);
    step("lw_wb", I_LW, 1'b1, 1'b0, 5);
    step("lw_next", I_ADD, 1'b0, 1'b0, 1);
    chk("lw_no_timeout", {31'b0, to}, 32'd0);

    // Stuck FETCH: watchdog fires after TO cycles; the disabled watchdog never does
    do_reset();
    step("to_idle", I_ADD, 1'b0, 1'b0, 0);
    for (int i = 0; i < TO; i++) begin
      chk("to_not_yet", {31'b0, to}, 32'd0);
      step("to_fetch", I_ADD, 1'b0, 1'b0, 1);
    end
    chk("to_set", {31'b0, to}, 32'd1);
    chk("to_refetch", {28'b0, st}, 32'd1);
    chk("to_disabled", {31'b0, to0}, 32'd0);
    chk("to_disabled_state", {28'b0, st0}, 32'd1);

    // Illegal opcode then sw stalled in MEM_WRITE, aborted by asynchronous reset
    step("ill_fetch", I_ILL, 1'b1, 1'b0, 1);
    step("ill_dec", I_ILL, 1'b1, 1'b0, 2);
    step("sw_fetch", I_SW, 1'b1, 1'b0, 1);
    step("sw_dec", I_SW, 1'b1, 1'b0, 2);
    step("sw_addr", I_SW, 1'b1, 1'b0, 3);
    step("sw_wait", I_SW, 1'b0, 1'b0, 6);
    step("sw_wait", I_SW, 1'b0, 1'b0, 6);
    chk("sw_flags_set", {30'b0, ill, to}, 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_state", {28'b0, st}, 32'd0);
    chk("async_ctl", {17'b0, d_ctl}, 32'd0);
    chk("async_flags", {30'b0, ill, to}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Randomized traffic against the reference model
    model_reset();
    thr = 8;
    for (int c = 0; c < 4000; c++) begin
      if (c % 100 == 0) thr = $urandom_range(1, 10);
      if (m_state <= 1) begin
        case ($urandom_range(0, 7))
          0: instr = I_ADD;  1: instr = I_LW;   2: instr = I_SW;   3: instr = I_BEQ;
          4: instr = I_J;    5: instr = I_ADDI; 6: instr = I_ILL;  default: instr = I_LUI;
        endcase
      end
      rdy  = ($urandom_range(0, 9) < thr);
      zero = $urandom_range(0, 1) == 1;
      #1;
      chk($sformatf("rand%0d", c), {11'b0, st, d_ctl, ill, to},
          {11'b0, m_state[3:0], exp_ctl(m_state, rdy, zero), m_ill, m_to});
      model_step(instr, rdy);
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
